// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param
//  Description : Parametrised register file, DEPTH x WIDTH, one synchronous
//                write port and two combinational read ports. Optional
//                hardwired-zero entry 0 (ZERO_REG) and optional write-through
//                forwarding enabled by defining the macro REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrenable,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [WIDTH-1:0]      wrdata,
    input  logic [ADDR_WIDTH-1:0] rdaddr1,
    output logic [WIDTH-1:0]      rddata1,
    input  logic [ADDR_WIDTH-1:0] rdaddr2,
    output logic [WIDTH-1:0]      rddata2
);

    // DEPTH expressed in ADDR_WIDTH+1 bits so it can hold 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0] c_depth   = DEPTH[ADDR_WIDTH:0];
    localparam logic                c_zero_en = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_wr_addr_ok;
    logic w_wr_valid;
    logic w_rd1_ok;
    logic w_rd2_ok;

    // Address qualification: in range, and not the hardwired zero entry
    always_comb begin
        w_wr_addr_ok = ({1'b0, wraddr} < c_depth) &&
                       !(c_zero_en && (wraddr == '0));
        w_rd1_ok     = ({1'b0, rdaddr1} < c_depth) &&
                       !(c_zero_en && (rdaddr1 == '0));
        w_rd2_ok     = ({1'b0, rdaddr2} < c_depth) &&
                       !(c_zero_en && (rdaddr2 == '0));
        w_wr_valid   = wrenable && w_wr_addr_ok && !reset;
    end

    // Storage: reset clears everything and overrides any same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_mem[wraddr] <= wrdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read port 1 with write-through forwarding from a valid in-flight write
    always_comb begin
        rddata1 = '0;
        if (w_rd1_ok) begin
            if (w_wr_valid && (rdaddr1 == wraddr)) begin
                rddata1 = wrdata;
            end else begin
                rddata1 = r_mem[rdaddr1];
            end
        end
    end

    // Read port 2 with write-through forwarding from a valid in-flight write
    always_comb begin
        rddata2 = '0;
        if (w_rd2_ok) begin
            if (w_wr_valid && (rdaddr2 == wraddr)) begin
                rddata2 = wrdata;
            end else begin
                rddata2 = r_mem[rdaddr2];
            end
        end
    end
`else
    // Read port 1: stored contents; zero entry and out-of-range read as 0
    always_comb begin
        rddata1 = '0;
        if (w_rd1_ok) begin
            rddata1 = r_mem[rdaddr1];
        end
    end

    // Read port 2: stored contents; zero entry and out-of-range read as 0
    always_comb begin
        rddata2 = '0;
        if (w_rd2_ok) begin
            rddata2 = r_mem[rdaddr2];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_param
//  Description : Directed self-checking bench for regfile_param. Three
//                instances share the inputs: default config, ZERO_REG=0,
//                and DEPTH=20.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        wrenable;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
    logic [4:0]  rdaddr1;
    logic [4:0]  rdaddr2;
    logic [31:0] rd1_a, rd2_a;   // default instance
    logic [31:0] rd1_z, rd2_z;   // ZERO_REG = 0
    logic [31:0] rd1_d, rd2_d;   // DEPTH = 20

    int errors = 0;
    int checks = 0;

    regfile_param dut (
        .clk(clk), .reset(reset), .wrenable(wrenable), .wraddr(wraddr),
        .wrdata(wrdata), .rdaddr1(rdaddr1), .rddata1(rd1_a),
        .rdaddr2(rdaddr2), .rddata2(rd2_a)
    );

    regfile_param #(.ZERO_REG(0)) dut_z0 (
        .clk(clk), .reset(reset), .wrenable(wrenable), .wraddr(wraddr),
        .wrdata(wrdata), .rdaddr1(rdaddr1), .rddata1(rd1_z),
        .rdaddr2(rdaddr2), .rddata2(rd2_z)
    );

    regfile_param #(.DEPTH(20)) dut_d20 (
        .clk(clk), .reset(reset), .wrenable(wrenable), .wraddr(wraddr),
        .wrdata(wrdata), .rdaddr1(rdaddr1), .rddata1(rd1_d),
        .rdaddr2(rdaddr2), .rddata2(rd2_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write cycle: drive at negedge, release 1 time unit after the posedge
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wrenable = 1'b1;
        wraddr   = a;
        wrdata   = d;
        @(posedge clk);
        #1;
        wrenable = 1'b0;
    endtask

    // Put both read addresses on the bus and let them settle
    task automatic set_read(input logic [4:0] a1, input logic [4:0] a2);
        rdaddr1 = a1;
        rdaddr2 = a2;
        #1;
    endtask

    task automatic test_pre_reset();
        set_read(5'd0, 5'd0);
        checks++;
        if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
            errors++;
            $display("FAIL pre_reset_zero_reg: got %h/%h expected 0", rd1_a, rd2_a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_read(5'(i), 5'(31 - i));
            checks++;
            if (rd1_a !== 32'h0 || rd2_a !== 32'h0 || rd1_z !== 32'h0 ||
                rd2_z !== 32'h0 || rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d: got %h %h %h %h %h %h expected 0",
                         i, rd1_a, rd2_a, rd1_z, rd2_z, rd1_d, rd2_d);
            end
        end
    endtask

    task automatic test_write();
        do_write(5'd7, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        set_read(5'd7, 5'd31);
        checks++;
        if (rd1_a !== 32'hDEADBEEF || rd2_a !== 32'h12345678) begin
            errors++;
            $display("FAIL write_read: got %h/%h expected deadbeef/12345678", rd1_a, rd2_a);
        end
        // DEPTH=20 instance drops the write to 31
        checks++;
        if (rd1_d !== 32'hDEADBEEF || rd2_d !== 32'h0) begin
            errors++;
            $display("FAIL write_read_d20: got %h/%h expected deadbeef/0", rd1_d, rd2_d);
        end
        for (int i = 0; i < 32; i++) begin
            if (i != 7 && i != 31) begin
                set_read(5'(i), 5'(i));
                checks++;
                if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
                    errors++;
                    $display("FAIL write_others addr=%0d: got %h/%h expected 0", i, rd1_a, rd2_a);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFFFFFF);
        set_read(5'd0, 5'd0);
        checks++;
        if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_on: got %h/%h expected 0", rd1_a, rd2_a);
        end
        checks++;
        if (rd1_z !== 32'hFFFFFFFF || rd2_z !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_reg_off: got %h/%h expected ffffffff", rd1_z, rd2_z);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        do_write(5'd25, 32'hAAAA5555);
        set_read(5'd25, 5'd25);
        checks++;
        if (rd1_d !== 32'h0 || rd2_d !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_d20: got %h/%h expected 0", rd1_d, rd2_d);
        end
        checks++;
        if (rd1_a !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL inrange_write_25: got %h expected aaaa5555", rd1_a);
        end
        for (int i = 0; i < 20; i++) begin
            exp = (i == 7) ? 32'hDEADBEEF : 32'h0;
            set_read(5'(i), 5'(i));
            checks++;
            if (rd1_d !== exp || rd2_d !== exp) begin
                errors++;
                $display("FAIL oor_unchanged addr=%0d: got %h/%h expected %h", i, rd1_d, rd2_d, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset    = 1'b1;
        wrenable = 1'b1;
        wraddr   = 5'd3;
        wrdata   = 32'h00000042;
        rdaddr1  = 5'd3;
        rdaddr2  = 5'd7;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wrenable = 1'b0;
        #1;
        checks++;
        if (rd1_a !== 32'h0 || rd2_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_priority: got %h/%h expected 0/0", rd1_a, rd2_a);
        end
        set_read(5'd0, 5'd31);
        checks++;
        if (rd1_z !== 32'h0 || rd2_a !== 32'h0) begin
            errors++;
            $display("FAIL midstream_clear: got %h/%h expected 0/0", rd1_z, rd2_a);
        end
        do_write(5'd3, 32'h00000042);
        set_read(5'd3, 5'd3);
        checks++;
        if (rd1_a !== 32'h42 || rd2_a !== 32'h42) begin
            errors++;
            $display("FAIL write_after_reset: got %h/%h expected 42", rd1_a, rd2_a);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h0BADF00D;
`else
        exp_pre = 32'h0;
`endif
        @(negedge clk);
        wrenable = 1'b1;
        wraddr   = 5'd5;
        wrdata   = 32'h0BADF00D;
        rdaddr1  = 5'd5;
        rdaddr2  = 5'd5;
        #1;
        checks++;
        if (rd1_a !== exp_pre || rd2_a !== exp_pre) begin
            errors++;
            $display("FAIL bypass_pre_edge: got %h/%h expected %h", rd1_a, rd2_a, exp_pre);
        end
        @(posedge clk);
        #1;
        wrenable = 1'b0;
        #1;
        checks++;
        if (rd1_a !== 32'h0BADF00D || rd2_a !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL bypass_post_edge: got %h/%h expected 0badf00d", rd1_a, rd2_a);
        end
        // Invalid write targets never forward
        @(negedge clk);
        wrenable = 1'b1;
        wraddr   = 5'd0;
        wrdata   = 32'h11111111;
        rdaddr1  = 5'd0;
        rdaddr2  = 5'd5;
        #1;
        checks++;
        if (rd1_a !== 32'h0 || rd2_a !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL bypass_zero_suppress: got %h/%h expected 0/0badf00d", rd1_a, rd2_a);
        end
        wraddr  = 5'd25;
        rdaddr1 = 5'd25;
        #1;
        checks++;
        if (rd1_d !== 32'h0) begin
            errors++;
            $display("FAIL bypass_oor_suppress: got %h expected 0", rd1_d);
        end
        @(posedge clk);
        #1;
        wrenable = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wrenable = 1'b1;
        wraddr   = 5'd10;
        rdaddr1  = 5'd10;
        rdaddr2  = 5'd10;
        for (int k = 1; k <= 3; k++) begin
            wrdata = 32'(k * 32'h01010101);
            @(posedge clk);
            #1;
            checks++;
            if (rd1_a !== 32'(k * 32'h01010101) || rd2_a !== rd1_a) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %h/%h expected %h",
                         k, rd1_a, rd2_a, 32'(k * 32'h01010101));
            end
        end
        // Constant address and data: repeated writes leave the value unchanged
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        wrenable = 1'b0;
        checks++;
        if (rd1_a !== 32'h03030303) begin
            errors++;
            $display("FAIL idempotent_hold: got %h expected 03030303", rd1_a);
        end
    endtask

    initial begin
        reset    = 1'b0;
        wrenable = 1'b0;
        wraddr   = '0;
        wrdata   = '0;
        rdaddr1  = '0;
        rdaddr2  = '0;
        #2;
        test_pre_reset();
        test_reset();
        test_write();
        test_zero_reg();
        test_out_of_range();
        test_reset_priority();
        test_bypass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
